// File: rtl/aes_stim_seq.sv
// aes_stim_seq: LFSR-driven stimulus sequencer for a fixed-latency pipelined AES core.
// Define AES_STIM_MISR_EN to build the result signature register; otherwise signature is tied to 0.
module aes_stim_seq #(
  parameter int unsigned       DATA_W     = 128,
  parameter int unsigned       LATENCY    = 21,
  parameter int unsigned       CNT_W      = 32,
  parameter int unsigned       REPEATS    = 2,
  parameter logic [DATA_W-1:0] TAPS       = 128'h8000_0000_0000_0000_0000_0028_0000_0002,
  parameter logic [DATA_W-1:0] STATE_SEED = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF,
  parameter logic [DATA_W-1:0] KEY_SEED   = 128'hCAFE_FEED_CAFE_FEED_CAFE_FEED_CAFE_FEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_tests,
  output logic [DATA_W-1:0] state_out,
  output logic [DATA_W-1:0] key_out,
  output logic              in_valid,
  input  logic [DATA_W-1:0] aes_out,
  output logic              out_valid,
  output logic [CNT_W-1:0]  out_idx,
  output logic [DATA_W-1:0] signature,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] LAST_SET = CNT_W'(REPEATS - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] cur);
    return {cur[DATA_W-2:0], ~^(cur & TAPS)};
  endfunction

  state_e             st_q;
  logic [DATA_W-1:0]  pt_lfsr_q;
  logic [DATA_W-1:0]  key_lfsr_q;
  logic [CNT_W-1:0]   n_q;
  logic [CNT_W-1:0]   total_q;
  logic [CNT_W-1:0]   set_q;
  logic [CNT_W-1:0]   issue_q;
  logic [CNT_W-1:0]   retired_q;
  logic [CNT_W-1:0]   ret_idx_q;
  logic [CNT_W-1:0]   out_idx_q;
  logic [LATENCY-1:0] vld_q;
  logic [DATA_W-1:0]  state_out_q;
  logic [DATA_W-1:0]  key_out_q;
  logic               in_valid_q;
  logic               busy_q;
  logic               done_q;

  // vpipe[k] is in_valid delayed by k cycles; vpipe[LATENCY] is the registered out_valid.
  logic [LATENCY:0]   vpipe;
  logic               retire_pre;
  logic               out_valid_w;
  logic [CNT_W-1:0]   retire_nxt;

  assign vpipe       = {vld_q, in_valid_q};
  assign retire_pre  = vpipe[LATENCY-1];
  assign out_valid_w = vld_q[LATENCY-1];
  assign retire_nxt  = retired_q + CNT_W'(out_valid_w);

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= S_IDLE;
      pt_lfsr_q   <= STATE_SEED;
      key_lfsr_q  <= KEY_SEED;
      n_q         <= '0;
      total_q     <= '0;
      set_q       <= '0;
      issue_q     <= '0;
      retired_q   <= '0;
      ret_idx_q   <= '0;
      out_idx_q   <= '0;
      vld_q       <= '0;
      state_out_q <= '0;
      key_out_q   <= '0;
      in_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      in_valid_q <= 1'b0;
      done_q     <= 1'b0;
      case (st_q)
        S_IDLE: begin
          if (start) begin
            total_q   <= CNT_W'(REPEATS) * num_tests;
            retired_q <= '0;
            ret_idx_q <= '0;
            set_q     <= '0;
            if (num_tests != '0) begin
              n_q    <= num_tests;
              busy_q <= 1'b1;
              st_q   <= S_SEED;
            end else begin
              done_q <= 1'b1;
              st_q   <= S_DONE;
            end
          end
        end
        S_SEED: begin
          pt_lfsr_q  <= STATE_SEED;
          key_lfsr_q <= KEY_SEED;
          issue_q    <= '0;
          st_q       <= S_RUN;
        end
        S_RUN: begin
          in_valid_q  <= 1'b1;
          state_out_q <= pt_lfsr_q;
          key_out_q   <= key_lfsr_q;
          pt_lfsr_q   <= lfsr_step(pt_lfsr_q);
          key_lfsr_q  <= lfsr_step(key_lfsr_q);
          issue_q     <= issue_q + ONE;
          if (issue_q == n_q - ONE) begin
            if (set_q == LAST_SET) begin
              st_q <= S_DRAIN;
            end else begin
              set_q <= set_q + ONE;
              st_q  <= S_SEED;
            end
          end
        end
        S_DRAIN: begin
          // Look one retirement ahead so done follows the last out_valid directly.
          if (retire_nxt == total_q) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            st_q   <= S_DONE;
          end
        end
        S_DONE: begin
          st_q <= S_IDLE;
        end
        default: begin
          st_q <= S_IDLE;
        end
      endcase

      vld_q <= vpipe[LATENCY-1:0];
      if (out_valid_w) begin
        retired_q <= retire_nxt;
      end
      // Index is loaded one cycle early so it lines up with out_valid.
      if (retire_pre) begin
        out_idx_q <= ret_idx_q;
        ret_idx_q <= (ret_idx_q == n_q - ONE) ? '0 : ret_idx_q + ONE;
      end
    end
  end

  assign state_out = state_out_q;
  assign key_out   = key_out_q;
  assign in_valid  = in_valid_q;
  assign out_valid = out_valid_w;
  assign out_idx   = out_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef AES_STIM_MISR_EN
  logic [DATA_W-1:0] sig_q;

  // Rotate-and-xor compression of each retired result.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= '0;
    end else if (st_q == S_IDLE && start) begin
      sig_q <= '0;
    end else if (out_valid_w) begin
      sig_q <= {sig_q[DATA_W-2:0], sig_q[DATA_W-1]} ^ aes_out;
    end
  end

  assign signature = sig_q;
`else
  logic unused_aes_out;

  assign unused_aes_out = ^aes_out;
  assign signature      = '0;
`endif

endmodule
